enc8b10b_rd_select: RTL and testbench

//  Running-disparity (RD) stage of the 8b/10b encoder. Consumes the RD- and RD+ 10-bit codes from
//  the two lookup stages (both valid in the same cycle), selects one by the current RD, then updates RD.

---
 rtl/enc8b10b_rd_select.sv | 161 ++++++++++++++++
 tb/tb_enc8b10b_rd_select.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enc8b10b_rd_select.sv
// Running-disparity select/update stage of the 8b/10b encoder with a 2-entry skid buffer
// toward the serializer. Optional saturating disparity-error counter under `RD_ERR_CNT_EN.
module enc8b10b_rd_select #(
    parameter logic RD_INIT   = 1'b0,
    parameter int   CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 o_in_ready,
    input  logic [9:0]           i_code_minus,
    input  logic [9:0]           i_code_plus,
    input  logic                 i_k,
    input  logic                 i_k_err_minus,
    input  logic                 i_k_err_plus,
    input  logic                 i_rd_reinit,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [9:0]           o_symbol,
    output logic                 o_k,
    output logic                 o_k_error,
    output logic                 o_disp_error,
    output logic                 o_rd,
    input  logic                 i_err_clr,
    output logic [CNT_WIDTH-1:0] o_err_cnt
);

    // Payload layout: {symbol[9:0], k, k_error, disp_error, rd}
    localparam int PW = 14;

    logic          rd_reg;
    logic          rd_eff;
    logic          rd_new;
    logic [9:0]    sel_code;
    logic [9:0]    sym;
    logic          k_err;
    logic          disp_err;
    logic [3:0]    ones;
    logic [PW-1:0] new_payload;

    logic          out_valid_reg;
    logic [PW-1:0] out_data_reg;
    logic          skid_valid_reg;
    logic [PW-1:0] skid_data_reg;
    logic          in_ready_reg;
    logic          skid_valid_next;

    logic          in_fire;
    logic          out_fire;

    assign in_fire  = i_valid & in_ready_reg;
    assign out_fire = out_valid_reg & i_ready;

    // Reinit takes effect before a coincident selection.
    assign rd_eff   = i_rd_reinit ? RD_INIT : rd_reg;
    assign sel_code = rd_eff ? i_code_plus : i_code_minus;
    assign k_err    = i_k & (rd_eff ? i_k_err_plus : i_k_err_minus);

    always_comb begin
        ones = 4'd0;
        for (int i = 0; i < 10; i++) begin
            ones = ones + 4'(sel_code[i]);
        end
    end

    always_comb begin
        sym      = sel_code;
        disp_err = 1'b0;
        rd_new   = rd_eff;
        if (k_err) begin
            sym = 10'd0;
        end else if (ones == 4'd5) begin
            rd_new = rd_eff;
        end else if (ones == 4'd6 && !rd_eff) begin
            rd_new = 1'b1;
        end else if (ones == 4'd4 && rd_eff) begin
            rd_new = 1'b0;
        end else begin
            // Illegal disparity: pass the code through but resynchronise to RD-.
            disp_err = 1'b1;
            rd_new   = 1'b0;
        end
    end

    assign new_payload = {sym, i_k, k_err, disp_err, rd_new};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_reg <= RD_INIT;
        end else if (in_fire) begin
            rd_reg <= rd_new;
        end else if (i_rd_reinit) begin
            rd_reg <= RD_INIT;
        end
    end

    // Skid only fills when the output register is stalled; it always drains first.
    always_comb begin
        skid_valid_next = skid_valid_reg;
        if (!out_valid_reg || out_fire) begin
            skid_valid_next = 1'b0;
        end else if (in_fire) begin
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            in_ready_reg   <= 1'b1;
        end else begin
            skid_valid_reg <= skid_valid_next;
            in_ready_reg   <= !skid_valid_next;
            if (!out_valid_reg || out_fire) begin
                if (skid_valid_reg) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= skid_data_reg;
                end else if (in_fire) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= new_payload;
                end else begin
                    out_valid_reg <= 1'b0;
                end
            end else if (in_fire) begin
                skid_data_reg <= new_payload;
            end
        end
    end

    assign o_in_ready   = in_ready_reg;
    assign o_valid      = out_valid_reg;
    assign o_symbol     = out_data_reg[13:4];
    assign o_k          = out_data_reg[3];
    assign o_k_error    = out_data_reg[2];
    assign o_disp_error = out_data_reg[1];
    assign o_rd         = out_data_reg[0];

`ifdef RD_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (i_err_clr) begin
            err_cnt_reg <= '0;
        end else if (in_fire && disp_err && !(&err_cnt_reg)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign o_err_cnt = err_cnt_reg;
`else
    logic unused_err_clr;
    assign unused_err_clr = i_err_clr;
    assign o_err_cnt      = '0;
`endif

endmodule

// File: tb/tb_enc8b10b_rd_select.sv
// Directed self-checking bench for enc8b10b_rd_select; expected symbols/RD are hand-computed.
module tb_enc8b10b_rd_select;

    localparam logic [9:0] K285_M = 10'b0011111010;
    localparam logic [9:0] K285_P = 10'b1100000101;
    localparam logic [9:0] D215   = 10'b1010101010;
    localparam logic [9:0] NA     = 10'b1010101010;
    localparam logic [9:0] NB     = 10'b0101010101;
    localparam logic [9:0] NC     = 10'b1110001100;
    localparam logic [9:0] BAD7   = 10'b1111111000;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_in_ready;
    logic [9:0]  i_code_minus;
    logic [9:0]  i_code_plus;
    logic        i_k;
    logic        i_k_err_minus;
    logic        i_k_err_plus;
    logic        i_rd_reinit;
    logic        o_valid;
    logic        i_ready;
    logic [9:0]  o_symbol;
    logic        o_k;
    logic        o_k_error;
    logic        o_disp_error;
    logic        o_rd;
    logic        i_err_clr;
    logic [15:0] o_err_cnt;

    int total = 0;
    int bad   = 0;

`ifdef RD_ERR_CNT_EN
    localparam logic [15:0] CNT_ONE = 16'd1;
`else
    localparam logic [15:0] CNT_ONE = 16'd0;
`endif

    enc8b10b_rd_select dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_valid      (i_valid),
        .o_in_ready   (o_in_ready),
        .i_code_minus (i_code_minus),
        .i_code_plus  (i_code_plus),
        .i_k          (i_k),
        .i_k_err_minus(i_k_err_minus),
        .i_k_err_plus (i_k_err_plus),
        .i_rd_reinit  (i_rd_reinit),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_symbol     (o_symbol),
        .o_k          (o_k),
        .o_k_error    (o_k_error),
        .o_disp_error (o_disp_error),
        .o_rd         (o_rd),
        .i_err_clr    (i_err_clr),
        .o_err_cnt    (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] m, input logic [9:0] p,
                         input logic k, input logic km, input logic kp);
        i_valid       = v;
        i_code_minus  = m;
        i_code_plus   = p;
        i_k           = k;
        i_k_err_minus = km;
        i_k_err_plus  = kp;
    endtask

    task automatic test_reset();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        total++; if (o_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", o_in_ready); end
        total++; if ({o_symbol, o_k, o_k_error, o_disp_error, o_rd} !== 14'd0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=0", {o_symbol, o_k, o_k_error, o_disp_error, o_rd}); end
        total++; if (o_err_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", o_err_cnt); end
        $display("reset checked");
    endtask

    task automatic test_k285();
        i_ready = 1'b1;
        drive(1'b1, K285_M, K285_P, 1'b1, 1'b0, 1'b0);
        tick();
        $display("k285 #1 sym=%b rd=%b", o_symbol, o_rd);
        total++; if (!(o_valid === 1'b1 && o_symbol === K285_M && o_rd === 1'b1 && o_k === 1'b1)) begin
            bad++; $display("FAIL k285_first got v=%b sym=%b rd=%b k=%b exp v=1 sym=%b rd=1 k=1", o_valid, o_symbol, o_rd, o_k, K285_M); end
        total++; if ({o_k_error, o_disp_error} !== 2'b00) begin
            bad++; $display("FAIL k285_first_err got=%b exp=00", {o_k_error, o_disp_error}); end
        tick();
        drive(1'b0, K285_M, K285_P, 1'b0, 1'b0, 1'b0);
        $display("k285 #2 sym=%b rd=%b", o_symbol, o_rd);
        total++; if (!(o_valid === 1'b1 && o_symbol === K285_P && o_rd === 1'b0 && o_k === 1'b1 && o_disp_error === 1'b0)) begin
            bad++; $display("FAIL k285_second got v=%b sym=%b rd=%b exp v=1 sym=%b rd=0", o_valid, o_symbol, o_rd, K285_P); end
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL k285_drained got=%b exp=0", o_valid); end
    endtask

    task automatic test_neutral();
        drive(1'b1, D215, D215, 1'b0, 1'b0, 1'b0);
        tick();
        $display("neutral rd- sym=%b rd=%b", o_symbol, o_rd);
        total++; if (!(o_symbol === D215 && o_rd === 1'b0 && o_k === 1'b0 && o_disp_error === 1'b0)) begin
            bad++; $display("FAIL neutral_rdm got sym=%b rd=%b exp sym=%b rd=0", o_symbol, o_rd, D215); end
        drive(1'b1, K285_M, K285_P, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (o_rd !== 1'b1) begin bad++; $display("FAIL neutral_to_rdp got=%b exp=1", o_rd); end
        drive(1'b1, D215, D215, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, D215, D215, 1'b0, 1'b0, 1'b0);
        $display("neutral rd+ sym=%b rd=%b", o_symbol, o_rd);
        total++; if (!(o_symbol === D215 && o_rd === 1'b1 && o_disp_error === 1'b0)) begin
            bad++; $display("FAIL neutral_rdp got sym=%b rd=%b exp sym=%b rd=1", o_symbol, o_rd, D215); end
        tick();
    endtask

    task automatic test_disp_error();
        // RD+ -> RD- via K28.5 RD+ code (4 ones)
        drive(1'b1, K285_M, K285_P, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (o_rd !== 1'b0) begin bad++; $display("FAIL disp_setup_rd got=%b exp=0", o_rd); end
        drive(1'b1, BAD7, 10'b0000000111, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, BAD7, 10'b0000000111, 1'b0, 1'b0, 1'b0);
        $display("disp sym=%b err=%b rd=%b cnt=%0d", o_symbol, o_disp_error, o_rd, o_err_cnt);
        total++; if (!(o_symbol === BAD7 && o_disp_error === 1'b1 && o_rd === 1'b0)) begin
            bad++; $display("FAIL disp_flag got sym=%b err=%b rd=%b exp sym=%b err=1 rd=0", o_symbol, o_disp_error, o_rd, BAD7); end
        total++; if (o_err_cnt !== CNT_ONE) begin bad++; $display("FAIL disp_cnt got=%0d exp=%0d", o_err_cnt, CNT_ONE); end
        i_err_clr = 1'b1;
        tick();
        total++; if (o_err_cnt !== 16'd0) begin bad++; $display("FAIL cnt_clear got=%0d exp=0", o_err_cnt); end
        // clear must beat a same-cycle increment
        drive(1'b1, BAD7, BAD7, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, BAD7, BAD7, 1'b0, 1'b0, 1'b0);
        i_err_clr = 1'b0;
        total++; if (!(o_err_cnt === 16'd0 && o_disp_error === 1'b1)) begin
            bad++; $display("FAIL clr_wins got cnt=%0d err=%b exp cnt=0 err=1", o_err_cnt, o_disp_error); end
        tick();
    endtask

    task automatic test_k_error();
        drive(1'b1, K285_M, K285_P, 1'b1, 1'b1, 1'b0);
        tick();
        $display("kerr sym=%b kerr=%b rd=%b", o_symbol, o_k_error, o_rd);
        total++; if (!(o_symbol === 10'd0 && o_k_error === 1'b1 && o_k === 1'b1 && o_disp_error === 1'b0 && o_rd === 1'b0)) begin
            bad++; $display("FAIL k_error got sym=%b kerr=%b k=%b derr=%b rd=%b exp 0/1/1/0/0", o_symbol, o_k_error, o_k, o_disp_error, o_rd); end
        // lookup error flag is ignored for data words
        drive(1'b1, D215, K285_P, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b0, D215, D215, 1'b0, 1'b0, 1'b0);
        total++; if (!(o_symbol === D215 && o_k_error === 1'b0 && o_k === 1'b0 && o_rd === 1'b0)) begin
            bad++; $display("FAIL k_error_data got sym=%b kerr=%b exp sym=%b kerr=0", o_symbol, o_k_error, D215); end
        tick();
    endtask

    task automatic test_back_to_back();
        i_ready = 1'b0;
        drive(1'b1, NA, NA, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, NB, NB, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, NC, NC, 1'b0, 1'b0, 1'b0);
        total++; if (!(o_in_ready === 1'b0 && o_valid === 1'b1 && o_symbol === NA)) begin
            bad++; $display("FAIL bp_full got rdy=%b v=%b sym=%b exp rdy=0 v=1 sym=%b", o_in_ready, o_valid, o_symbol, NA); end
        tick();
        total++; if (!(o_in_ready === 1'b0 && o_symbol === NA && o_rd === 1'b0)) begin
            bad++; $display("FAIL bp_hold got rdy=%b sym=%b exp rdy=0 sym=%b", o_in_ready, o_symbol, NA); end
        i_ready = 1'b1;
        tick();
        $display("drain sym=%b", o_symbol);
        total++; if (!(o_valid === 1'b1 && o_symbol === NB && o_in_ready === 1'b1)) begin
            bad++; $display("FAIL bp_drain_b got v=%b sym=%b rdy=%b exp v=1 sym=%b rdy=1", o_valid, o_symbol, o_in_ready, NB); end
        tick();
        drive(1'b0, NC, NC, 1'b0, 1'b0, 1'b0);
        $display("drain sym=%b", o_symbol);
        total++; if (!(o_valid === 1'b1 && o_symbol === NC)) begin
            bad++; $display("FAIL bp_drain_c got v=%b sym=%b exp v=1 sym=%b", o_valid, o_symbol, NC); end
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b exp=0", o_valid); end
    endtask

    task automatic test_reinit_and_reset();
        drive(1'b1, K285_M, K285_P, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (o_rd !== 1'b1) begin bad++; $display("FAIL reinit_setup got=%b exp=1", o_rd); end
        i_rd_reinit = 1'b1;
        tick();
        i_rd_reinit = 1'b0;
        drive(1'b0, K285_M, K285_P, 1'b0, 1'b0, 1'b0);
        $display("reinit sym=%b rd=%b", o_symbol, o_rd);
        total++; if (!(o_symbol === K285_M && o_rd === 1'b1)) begin
            bad++; $display("FAIL reinit_sel got sym=%b rd=%b exp sym=%b rd=1", o_symbol, o_rd, K285_M); end
        tick();
        // RD is now + ; fill buffer then reset asynchronously
        i_ready = 1'b0;
        drive(1'b1, NA, NB, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (!(o_valid === 1'b0 && o_in_ready === 1'b1 && o_rd === 1'b0)) begin
            bad++; $display("FAIL async_reset got v=%b rdy=%b rd=%b exp 0/1/0", o_valid, o_in_ready, o_rd); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        i_ready = 1'b1;
        tick();
        drive(1'b0, NA, NB, 1'b0, 1'b0, 1'b0);
        $display("post-reset sym=%b rd=%b", o_symbol, o_rd);
        total++; if (!(o_valid === 1'b1 && o_symbol === NA && o_rd === 1'b0)) begin
            bad++; $display("FAIL reset_rd_init got v=%b sym=%b exp v=1 sym=%b", o_valid, o_symbol, NA); end
        tick();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_no_dup got=%b exp=0", o_valid); end
    endtask

    initial begin
        rst_n       = 1'b0;
        i_ready     = 1'b1;
        i_rd_reinit = 1'b0;
        i_err_clr   = 1'b0;
        drive(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        tick();
        test_k285();
        test_neutral();
        test_disp_error();
        test_k_error();
        test_back_to_back();
        test_reinit_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
